// File: rtl/aes_packet_writer_if.sv
// Host-word and packet-consumer bus of the AES packet writer.
interface aes_packet_writer_if;
    logic         host_valid;
    logic         host_ready;
    logic [31:0]  host_data;
    logic         host_is_key;
    logic         load_data;
    logic         pkt_valid;
    logic         pkt_set_key;
    logic [127:0] pkt_data;

    // Host and AES-controller side of the bus
    modport master (
        output host_valid, host_data, host_is_key, load_data,
        input  host_ready, pkt_valid, pkt_set_key, pkt_data
    );

    // Writer side of the bus
    modport slave (
        input  host_valid, host_data, host_is_key, load_data,
        output host_ready, pkt_valid, pkt_set_key, pkt_data
    );
endinterface

// File: rtl/aes_packet_writer.sv
// AES packet writer: assembles four 32-bit host words into 128-bit key/data
// packets and queues them in a 4-entry FIFO for the AES controller.
// Optional macro AES_WRITER_PKT_CNT_EN adds a 16-bit popped-packet counter.
module aes_packet_writer (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_packet_writer_if.slave   bus,
    input  logic                 flush,
    output logic [2:0]           fifo_level,
    output logic                 err_mix
`ifdef AES_WRITER_PKT_CNT_EN
    ,
    output logic [15:0]          pkt_count
`endif
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned PKT_W   = 128;
    localparam int unsigned ASM_W   = 96;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned ENTRY_W = PKT_W + 1;

    logic [1:0]         word_cnt_q,  word_cnt_d;
    logic               word_key_q,  word_key_d;
    logic [ASM_W-1:0]   asm_q,       asm_d;
    logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [LVL_W-1:0]   level_q,     level_d;
    logic               ready_q,     ready_d;
    logic               valid_q,     valid_d;
    logic [ENTRY_W-1:0] head_q,      head_d;
    logic               err_q,       err_d;
`ifdef AES_WRITER_PKT_CNT_EN
    logic [15:0]        cnt_q,       cnt_d;
`endif

    logic               accept;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] mem [DEPTH];

    // Next-state: word assembly, FIFO pointers/level and registered head view
    always_comb begin
        word_cnt_d = word_cnt_q;
        word_key_d = word_key_q;
        asm_d      = asm_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        err_d      = 1'b0;
        push       = 1'b0;
        push_entry = {word_key_q, asm_q, bus.host_data};
`ifdef AES_WRITER_PKT_CNT_EN
        cnt_d      = cnt_q;
`endif
        accept = bus.host_valid && ready_q;
        pop    = valid_q && bus.load_data;

        if (accept) begin
            if ((word_cnt_q != 2'd0) && (bus.host_is_key != word_key_q)) begin
                // Type changed mid-packet: drop the partial, restart with this word
                err_d                      = 1'b1;
                word_key_d                 = bus.host_is_key;
                asm_d[ASM_W-1 -: WORD_W]   = bus.host_data;
                word_cnt_d                 = 2'd1;
            end else begin
                if (word_cnt_q == 2'd0) begin
                    word_key_d = bus.host_is_key;
                end
                case (word_cnt_q)
                    2'd0:    asm_d[95:64] = bus.host_data;
                    2'd1:    asm_d[63:32] = bus.host_data;
                    2'd2:    asm_d[31:0]  = bus.host_data;
                    default: push         = 1'b1;
                endcase
                word_cnt_d = 2'(word_cnt_q + 2'd1);
            end
        end

        if (pop) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        if (push) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        end
        case ({push, pop})
            2'b10:   level_d = LVL_W'(level_q + 1'b1);
            2'b01:   level_d = LVL_W'(level_q - 1'b1);
            default: level_d = level_q;
        endcase
`ifdef AES_WRITER_PKT_CNT_EN
        if (pop) begin
            cnt_d = 16'(cnt_q + 16'd1);
        end
`endif

        if (flush) begin
            word_cnt_d = 2'd0;
            word_key_d = 1'b0;
            asm_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            err_d      = 1'b0;
            push       = 1'b0;
`ifdef AES_WRITER_PKT_CNT_EN
            cnt_d      = '0;
`endif
        end

        ready_d = (level_d != LVL_W'(DEPTH));
        valid_d = (level_d != '0);
        // Head after the edge is the entry being pushed when nothing else remains
        if (level_d == '0) begin
            head_d = '0;
        end else if (level_q == LVL_W'(pop)) begin
            head_d = push_entry;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= 2'd0;
            word_key_q <= 1'b0;
            asm_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            head_q     <= '0;
            err_q      <= 1'b0;
`ifdef AES_WRITER_PKT_CNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            word_cnt_q <= word_cnt_d;
            word_key_q <= word_key_d;
            asm_q      <= asm_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            err_q      <= err_d;
`ifdef AES_WRITER_PKT_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Packet storage; contents are qualified by the level so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    assign bus.host_ready  = ready_q;
    assign bus.pkt_valid   = valid_q;
    assign bus.pkt_set_key = head_q[PKT_W];
    assign bus.pkt_data    = head_q[PKT_W-1:0];
    assign fifo_level      = level_q;
    assign err_mix         = err_q;
`ifdef AES_WRITER_PKT_CNT_EN
    assign pkt_count       = cnt_q;
`endif

endmodule

// File: doc/aes_packet_writer.md
AES_PACKET_WRITER -- requirements
Module: aes_packet_writer

Interface
REQ-001 Reset rst_n SHALL be asynchronous, active-low; clock clk; all state SHALL be on posedge clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 host_valid  input  1  host word valid.
REQ-005 host_ready  output  1  writer can accept a word this cycle.
REQ-006 host_data  input  32  host word.
REQ-007 host_is_key  input  1  word belongs to a key packet (1) or a data packet (0); sampled with each accepted word.
REQ-008 flush  input  1  synchronous clear of the assembler and the FIFO.
REQ-009 load_data  input  1  consumer pop strobe from the AES controller.
REQ-010 pkt_valid  output  1  packet presented to the controller.
REQ-011 pkt_set_key  output  1  presented packet is a key packet.
REQ-012 pkt_data  output  128  presented packet payload.
REQ-013 fifo_level  output  3  packets stored, 0..4.
REQ-014 err_mix  output  1  one-cycle pulse on a discarded partial packet.

Function
REQ-015 An accepted word SHALL be host_valid && host_ready at a rising edge.
REQ-016 The assembler SHALL count words 0..3; word 0 SHALL fill pkt bits [127:96], word 1 [95:64], word 2 [63:32], word 3 [31:0].
REQ-017 Accepting word 3 SHALL push {host_is_key, 128-bit packet} into a 4-entry FIFO and return the word count to 0.
REQ-018 If host_is_key of an accepted word 1..3 differs from that of word 0, the partial packet SHALL be discarded, the new word SHALL become word 0, and err_mix SHALL pulse for one cycle.
REQ-019 host_ready SHALL be ~(fifo_level==4), registered state only, with no combinational path from load_data.
REQ-020 pkt_valid SHALL equal (fifo_level!=0); pkt_set_key and pkt_data SHALL show the FIFO head and SHALL be 0 when empty.
REQ-021 A pop SHALL occur at an edge where pkt_valid && load_data; load_data while empty SHALL have no effect.
REQ-022 Latency: word 3 accepted at edge N with the FIFO empty SHALL give pkt_valid=1 in the cycle after edge N; there SHALL be no same-cycle fall-through.
REQ-023 Simultaneous push and pop SHALL leave fifo_level unchanged and SHALL preserve order.
REQ-024 Read and write pointers SHALL be 2 bits and wrap 3->0; fifo_level SHALL never exceed 4 or go below 0.
REQ-025 flush SHALL take priority over push and pop: at the next edge, word count 0, FIFO empty, and any word accepted that cycle dropped.
REQ-026 Packets SHALL be emitted strictly in completion order, with key and data packets interleaved as received.

Reset
REQ-027 On rst_n low: word count 0, pointers 0, fifo_level 0, pkt_valid 0, pkt_set_key 0, pkt_data 0, err_mix 0, host_ready 1.
REQ-028 Reset asserted mid-packet SHALL discard the partial packet and all FIFO contents; the next accepted word after release SHALL be word 0.

Configuration
REQ-029 Macro AES_WRITER_PKT_CNT_EN: when defined, the block SHALL add output pkt_count[15:0], which increments on each pop, wraps 0xFFFF->0, and clears on reset and flush.
REQ-030 When AES_WRITER_PKT_CNT_EN is undefined, the pkt_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Key words 0x2B7E1516, 0x28AED2A6, 0xABF71588, 0x09CF4F3C with is_key=1 and load_data=0 -> next cycle pkt_valid=1, pkt_set_key=1, pkt_data=0x2B7E151628AED2A6ABF7158809CF4F3C, fifo_level=1.
REQ-032 Five data packets pushed with load_data=0 -> host_ready=0 after the 4th packet, fifo_level=4; one pop -> host_ready=1; 5th packet completes, order preserved.
REQ-033 Word 0 with is_key=1, then word 1 with is_key=0 -> err_mix pulses once, word count=1, word 1 becomes word 0 of a data packet.
REQ-034 fifo_level=2 with load_data=1 on the same edge as a word-3 push -> fifo_level stays 2 and the head advances; run 10 packets across pointer wrap, output order equals input order.
REQ-035 flush asserted with fifo_level=3 and word count=2 -> next cycle pkt_valid=0, pkt_data=0, fifo_level=0; the next 4 words form one packet.
REQ-036 rst_n pulsed low mid-packet with AES_WRITER_PKT_CNT_EN defined and pkt_count=7 -> all outputs at reset values, pkt_count=0.
